// File: rtl/frame_streamer_if.sv
// Pixel payload type and the valid/pixel stream interface shared by the
// frame source and the line-buffered filters.
package pixel_pkg;
  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } pixel_t;
endpackage

interface pixel_valid_if;
  import pixel_pkg::*;
  logic   valid;
  pixel_t pixel;

  modport master (output valid, output pixel);
  modport slave  (input  valid, input  pixel);
endinterface

// File: rtl/frame_streamer.sv
// Raster-order frame source: reads a frame from a 1-cycle-latency memory and
// streams it as valid/pixel with programmable pixel and line gaps.
module frame_streamer
  import pixel_pkg::*;
#(
  parameter int unsigned IMAGE_LEN    = 1080,
  parameter int unsigned IMAGE_HEIGHT = 720,
  parameter int unsigned GAP_CYCLES   = 0,
  parameter int unsigned LINE_GAP     = 0,
  parameter int unsigned MEM_AW       = $clog2(IMAGE_LEN * IMAGE_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              pause_i,
  output logic              mem_en_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic [23:0]       mem_data_i,
  pixel_valid_if.master     pixel_valid_if_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned XW = (IMAGE_LEN    > 1) ? $clog2(IMAGE_LEN)    : 1;
  localparam int unsigned YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int unsigned GW = $clog2(GAP_CYCLES + LINE_GAP + 2);

  typedef enum logic [1:0] {IDLE, RUN, WAIT, DRAIN} state_t;

  state_t            state;
  logic [MEM_AW-1:0] addr;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [GW-1:0]     gap_cnt;

  logic              x_last;
  logic              frame_last;
  logic              read_c;
  int unsigned       idle_cnt;

  logic              s1_vld;
  logic              s1_last;
  logic              vld_q;
  logic              done_q;
  pixel_t            pix_q;

  assign x_last     = (x == XW'(IMAGE_LEN - 1));
  assign frame_last = x_last && (y == YW'(IMAGE_HEIGHT - 1));
  assign idle_cnt   = GAP_CYCLES + (x_last ? LINE_GAP : 0);

  // The read is issued in the same cycle pause is seen low, so enable is a
  // decode of the registered state rather than a further register stage.
  assign read_c     = (state == RUN) && !pause_i;
  assign mem_en_o   = read_c;
  assign mem_addr_o = addr;
  assign busy_o     = (state != IDLE);

  // Sequencer: raster counters, gap countdown and drain timing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr    <= '0;
      x       <= '0;
      y       <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) state <= RUN;
        end
        RUN: begin
          if (!pause_i) begin
            if (frame_last) begin
              addr    <= '0;
              x       <= '0;
              y       <= '0;
              gap_cnt <= GW'(1);
              state   <= DRAIN;
            end else begin
              addr <= addr + MEM_AW'(1);
              if (x_last) begin
                x <= '0;
                y <= y + YW'(1);
              end else begin
                x <= x + XW'(1);
              end
              if (idle_cnt != 0) begin
                gap_cnt <= GW'(idle_cnt - 1);
                state   <= WAIT;
              end
            end
          end
        end
        WAIT: begin
          if (gap_cnt == '0) state <= RUN;
          else               gap_cnt <= gap_cnt - GW'(1);
        end
        DRAIN: begin
          if (gap_cnt == '0) state <= IDLE;
          else               gap_cnt <= gap_cnt - GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-stage output pipeline aligned to the memory read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      pix_q   <= '0;
    end else begin
      s1_vld  <= read_c;
      s1_last <= read_c && frame_last;
      vld_q   <= s1_vld;
      done_q  <= s1_last;
      if (s1_vld) pix_q <= pixel_t'(mem_data_i);
    end
  end

  assign pixel_valid_if_o.valid = vld_q;
  assign pixel_valid_if_o.pixel = pix_q;
  assign done_o                 = done_q;

endmodule

// File: tb/tb_frame_streamer.sv
// Directed bench for frame_streamer on a 4x3 frame whose memory holds
// pixel = address; one dense instance and one gapped instance.
module tb_frame_streamer;
  import pixel_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, pause1, start2, pause2;
  logic        en1, en2, busy1, busy2, done1, done2;
  logic [3:0]  addr1, addr2;
  logic [23:0] rd1, rd2;
  logic [23:0] pix1, pix2;

  int checks = 0;
  int errors = 0;

  pixel_valid_if pv1 ();
  pixel_valid_if pv2 ();

  frame_streamer #(.IMAGE_LEN(4), .IMAGE_HEIGHT(3), .GAP_CYCLES(0), .LINE_GAP(0)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .pause_i(pause1),
    .mem_en_o(en1), .mem_addr_o(addr1), .mem_data_i(rd1),
    .pixel_valid_if_o(pv1), .busy_o(busy1), .done_o(done1));

  frame_streamer #(.IMAGE_LEN(4), .IMAGE_HEIGHT(3), .GAP_CYCLES(1), .LINE_GAP(2)) dut2 (
    .clk(clk), .rst(rst), .start_i(start2), .pause_i(pause2),
    .mem_en_o(en2), .mem_addr_o(addr2), .mem_data_i(rd2),
    .pixel_valid_if_o(pv2), .busy_o(busy2), .done_o(done2));

  assign pix1 = 24'(pv1.pixel);
  assign pix2 = 24'(pv2.pixel);

  always #5 clk = ~clk;

  // Frame memories preloaded with pixel = address, 1-cycle read latency
  always @(posedge clk) begin
    if (en1) rd1 <= 24'(addr1);
    if (en2) rd2 <= 24'(addr2);
  end

  typedef struct {
    logic start;
    logic pause;
    logic en;
    int   addr;
    logic valid;
    int   pixel;
    logic done;
    logic busy;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic s_en(input int sel);    return sel == 0 ? en1 : en2;             endfunction
  function automatic int   s_addr(input int sel);  return sel == 0 ? int'(addr1) : int'(addr2); endfunction
  function automatic logic s_vld(input int sel);   return sel == 0 ? pv1.valid : pv2.valid; endfunction
  function automatic int   s_pix(input int sel);   return sel == 0 ? int'(pix1) : int'(pix2);   endfunction
  function automatic logic s_done(input int sel);  return sel == 0 ? done1 : done2;         endfunction

  // Drives start/pause masks cycle by cycle and checks every read, pixel and done
  task automatic run_seq(input int sel, input string name, input int ncyc,
                         input logic [63:0] start_m, input logic [63:0] pause_m,
                         input int exp_rd[$], input int exp_done[$]);
    int nrd = 0;
    int nv  = 0;
    int nd  = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (sel == 0) begin start1 = start_m[c]; pause1 = pause_m[c]; end
      else          begin start2 = start_m[c]; pause2 = pause_m[c]; end
      #1;
      if (s_en(sel)) begin
        chk({name, " read_cycle"}, c, nrd < exp_rd.size() ? exp_rd[nrd] : -1);
        chk({name, " read_addr"}, s_addr(sel), nrd % 12);
        nrd++;
      end
      if (s_vld(sel)) begin
        chk({name, " valid_cycle"}, c, nv < exp_rd.size() ? exp_rd[nv] + 2 : -1);
        chk({name, " pixel"}, s_pix(sel), nv % 12);
        nv++;
      end
      if (s_done(sel)) begin
        chk({name, " done_cycle"}, c, nd < exp_done.size() ? exp_done[nd] : -1);
        chk({name, " done_with_valid"}, int'(s_vld(sel)), 1);
        nd++;
      end
    end
    @(negedge clk);
    start1 = 1'b0; pause1 = 1'b0; start2 = 1'b0; pause2 = 1'b0;
    chk({name, " read_count"},  nrd, exp_rd.size());
    chk({name, " valid_count"}, nv,  exp_rd.size());
    chk({name, " done_count"},  nd,  exp_done.size());
  endtask

  initial begin
    int q_rd[$];
    int q_done[$];
    int n;
    logic found;

    // start, pause | en, addr, valid, pixel, done, busy
    tbl[0]  = '{1'b1, 1'b0, 1'b0,  0, 1'b0,  0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1,  0, 1'b0,  0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1,  1, 1'b0,  0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1,  2, 1'b1,  0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1,  3, 1'b1,  1, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1,  4, 1'b1,  2, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1,  5, 1'b1,  3, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1,  6, 1'b1,  4, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1,  7, 1'b1,  5, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1,  8, 1'b1,  6, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b1,  9, 1'b1,  7, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 10, 1'b1,  8, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 11, 1'b1,  9, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0,  0, 1'b1, 10, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b0,  0, 1'b1, 11, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 1'b0,  0, 1'b0, 11, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0,  0, 1'b0, 11, 1'b0, 1'b0};

    rst = 1'b1;
    start1 = 1'b0; pause1 = 1'b0; start2 = 1'b0; pause2 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset en",    int'(en1),       0);
    chk("reset addr",  int'(addr1),     0);
    chk("reset valid", int'(pv1.valid), 0);
    chk("reset pixel", int'(pix1),      0);
    chk("reset busy",  int'(busy1),     0);
    chk("reset done",  int'(done1),     0);
    chk("reset busy2", int'(busy2),     0);
    @(negedge clk);
    rst = 1'b0;

    // Dense frame, cycle-exact table
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      start1 = tbl[i].start;
      pause1 = tbl[i].pause;
      #1;
      chk($sformatf("dense c%0d en", i),    int'(en1),       int'(tbl[i].en));
      chk($sformatf("dense c%0d addr", i),  int'(addr1),     tbl[i].addr);
      chk($sformatf("dense c%0d valid", i), int'(pv1.valid), int'(tbl[i].valid));
      chk($sformatf("dense c%0d pixel", i), int'(pix1),      tbl[i].pixel);
      chk($sformatf("dense c%0d done", i),  int'(done1),     int'(tbl[i].done));
      chk($sformatf("dense c%0d busy", i),  int'(busy1),     int'(tbl[i].busy));
    end

    // Gapped frame: one read per 2 cycles, 2 extra idle cycles at line ends
    q_rd = '{1, 3, 5, 7, 11, 13, 15, 17, 21, 23, 25, 27};
    q_done = '{29};
    run_seq(1, "gapped", 32, 64'h1, 64'h0, q_rd, q_done);

    // Pause for cycles 5..9 of a dense frame
    q_rd = '{1, 2, 3, 4, 10, 11, 12, 13, 14, 15, 16, 17};
    q_done = '{19};
    run_seq(0, "pause", 22, 64'h1, 64'h3E0, q_rd, q_done);

    // Starts mid-frame and in DRAIN ignored; start at r+3 runs a second frame
    q_rd.delete();
    for (int i = 1; i <= 12; i++)  q_rd.push_back(i);
    for (int i = 16; i <= 27; i++) q_rd.push_back(i);
    q_done = '{14, 29};
    run_seq(0, "busy_start", 32, 64'hE041, 64'h0, q_rd, q_done);

    // Asynchronous reset mid-frame, between clock edges
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start1 = (i == 0);
      #1;
      if (pv1.valid && pix1 == 24'd6) begin
        found = 1'b1;
        break;
      end
    end
    start1 = 1'b0;
    chk("rst reached pixel6", int'(found), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst async en",    int'(en1),       0);
    chk("rst async addr",  int'(addr1),     0);
    chk("rst async valid", int'(pv1.valid), 0);
    chk("rst async pixel", int'(pix1),      0);
    chk("rst async busy",  int'(busy1),     0);
    chk("rst async done",  int'(done1),     0);
    n = 0;
    repeat (3) begin
      @(negedge clk); #1;
      n += int'(pv1.valid) + int'(done1) + int'(en1);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      n += int'(pv1.valid) + int'(done1) + int'(en1) + int'(busy1);
    end
    chk("rst no activity after", n, 0);

    q_rd.delete();
    for (int i = 1; i <= 12; i++) q_rd.push_back(i);
    q_done = '{14};
    run_seq(0, "after_rst", 17, 64'h1, 64'h0, q_rd, q_done);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
